// File: rtl/mac_sequencer.sv
// Control FSM for the matrix-multiply datapath: walks every (row, col) output element through
// DIM issue/wait/accumulate steps followed by a store, with a hold input for back-pressure.
module mac_sequencer #(
    parameter int unsigned DIM = 3,
    parameter int unsigned LAT = 4,
    localparam int unsigned IW = (DIM > 1) ? $clog2(DIM) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          hold,
    output logic          signalGenAddr,
    output logic          signalAcum,
    output logic          signalStore,
    output logic          done,
    output logic          busy,
    output logic [IW-1:0] row,
    output logic [IW-1:0] col,
    output logic [IW-1:0] k
);

    localparam int unsigned WW = (LAT > 1) ? $clog2(LAT) : 1;

    localparam logic [IW-1:0] IdxLast = IW'(DIM - 1);
    localparam logic [WW-1:0] WaitLast = WW'(LAT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StAcum,
        StStore,
        StDone
    } state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] row_q, row_d;
    logic [IW-1:0] col_q, col_d;
    logic [IW-1:0] k_q, k_d;
    logic [WW-1:0] wait_q, wait_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            row_q   <= '0;
            col_q   <= '0;
            k_q     <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            k_q     <= k_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        k_d     = k_q;
        wait_d  = wait_q;
        // hold freezes every register; the pending pulse re-fires once released
        if (!hold) begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_d = StIssue;
                        row_d   = '0;
                        col_d   = '0;
                        k_d     = '0;
                    end
                end
                StIssue: begin
                    state_d = StWait;
                    wait_d  = '0;
                end
                StWait: begin
                    if (wait_q == WaitLast) begin
                        wait_d  = '0;
                        state_d = StAcum;
                    end else begin
                        wait_d = wait_q + WW'(1);
                    end
                end
                StAcum: begin
                    if (k_q < IdxLast) begin
                        k_d     = k_q + IW'(1);
                        state_d = StIssue;
                    end else begin
                        state_d = StStore;
                    end
                end
                StStore: begin
                    k_d = '0;
                    if (row_q == IdxLast && col_q == IdxLast) begin
                        state_d = StDone;
                    end else begin
                        state_d = StIssue;
                        if (col_q == IdxLast) begin
                            col_d = '0;
                            row_d = row_q + IW'(1);
                        end else begin
                            col_d = col_q + IW'(1);
                        end
                    end
                end
                StDone: begin
                    state_d = StIdle;
                    row_d   = '0;
                    col_d   = '0;
                    k_d     = '0;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    assign signalGenAddr = (state_q == StIssue) && !hold;
    assign signalAcum    = (state_q == StAcum) && !hold;
    assign signalStore   = (state_q == StStore) && !hold;
    assign done          = (state_q == StDone) && !hold;
    assign busy          = (state_q != StIdle);
    assign row           = row_q;
    assign col           = col_q;
    assign k             = k_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer: a DIM=3/LAT=4 instance for the full matrix scenarios and a
// DIM=1/LAT=1 instance for the degenerate sequence.
module tb_mac_sequencer;

    logic clk = 1'b0;
    logic rst, start, hold, start1, hold1;

    logic       gen, acum, store, done, busy;
    logic [1:0] row, col, k;
    logic       gen1, acum1, store1, done1, busy1;
    logic [0:0] row1, col1, k1;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    mac_sequencer #(.DIM(3), .LAT(4)) u_dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .hold          (hold),
        .signalGenAddr (gen),
        .signalAcum    (acum),
        .signalStore   (store),
        .done          (done),
        .busy          (busy),
        .row           (row),
        .col           (col),
        .k             (k)
    );

    mac_sequencer #(.DIM(1), .LAT(1)) u_dut1 (
        .clk           (clk),
        .rst           (rst),
        .start         (start1),
        .hold          (hold1),
        .signalGenAddr (gen1),
        .signalAcum    (acum1),
        .signalStore   (store1),
        .done          (done1),
        .busy          (busy1),
        .row           (row1),
        .col           (col1),
        .k             (k1)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_total++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    // Per-run statistics filled by run_matrix
    int busy_cnt, done_cyc, gen_cnt, acum_cnt, store_cnt;
    int first_gen, second_gen, first_acum, second_acum, first_store;
    int first_store_rc, last_store_rc, order_err, hold_viol;

    // Cycle n is the period after rising edge n; start is high before edge 0.
    task automatic run_matrix(input int hs, input int hl, input int sp);
        int  er, ec, ek;
        bit  seen_done;
        er = 0; ec = 0; ek = 0; seen_done = 0;
        busy_cnt = 0; done_cyc = -1; gen_cnt = 0; acum_cnt = 0; store_cnt = 0;
        first_gen = -1; second_gen = -1; first_acum = -1; second_acum = -1;
        first_store = -1; first_store_rc = -1; last_store_rc = -1;
        order_err = 0; hold_viol = 0;
        @(posedge clk); #1;
        start = 1'b1;
        hold  = 1'b0;
        @(negedge clk);
        check("idle_before_start", int'(busy), 0);
        for (int cyc = 1; cyc <= 400 && !seen_done; cyc++) begin
            @(posedge clk); #1;
            start = (cyc == sp);
            hold  = (hl > 0 && cyc >= hs && cyc < hs + hl);
            @(negedge clk);
            if (hold && (gen || acum || store || done)) hold_viol++;
            if (busy) busy_cnt++;
            if (gen) begin
                gen_cnt++;
                if (gen_cnt == 1) first_gen = cyc;
                if (gen_cnt == 2) second_gen = cyc;
            end
            if (acum) begin
                acum_cnt++;
                if (acum_cnt == 1) first_acum = cyc;
                if (acum_cnt == 2) second_acum = cyc;
                if (int'(row) != er || int'(col) != ec || int'(k) != ek) order_err++;
                ek++;
                if (ek == 3) begin
                    ek = 0; ec++;
                    if (ec == 3) begin ec = 0; er++; end
                end
            end
            if (store) begin
                store_cnt++;
                if (store_cnt == 1) begin
                    first_store = cyc;
                    first_store_rc = int'(row) * 3 + int'(col);
                end
                last_store_rc = int'(row) * 3 + int'(col);
            end
            if (done) begin
                done_cyc  = cyc;
                seen_done = 1;
            end
        end
        start = 1'b0;
        hold  = 1'b0;
    endtask

    logic [4:0] exp_seq1 [0:6];
    int done_seen, busy_seen;

    initial begin
        rst = 1'b0; start = 1'b1; hold = 1'b0; start1 = 1'b1; hold1 = 1'b0;

        // Reset held for 3 cycles with start asserted
        repeat (3) @(negedge clk);
        check("reset_outputs", int'({gen, acum, store, done, busy, row, col, k}), 0);
        check("reset_outputs_dim1", int'({gen1, acum1, store1, done1, busy1, row1, col1, k1}), 0);
        start = 1'b0; start1 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_after_reset", int'(busy), 0);
        check("idle_after_reset_dim1", int'(busy1), 0);

        // Nominal run
        run_matrix(0, 0, 0);
        check("nom_busy_cycles", busy_cnt, 172);
        check("nom_done_cycle", done_cyc, 172);
        check("nom_gen_count", gen_cnt, 27);
        check("nom_acum_count", acum_cnt, 27);
        check("nom_store_count", store_cnt, 9);
        check("nom_first_gen", first_gen, 1);
        check("nom_first_acum", first_acum, 6);
        check("nom_first_store", first_store, 19);
        check("nom_first_store_rc", first_store_rc, 0);
        check("nom_last_store_rc", last_store_rc, 8);
        check("nom_index_order", order_err, 0);

        // Back-to-back: start in the cycle right after done
        run_matrix(0, 0, 0);
        check("b2b_busy_cycles", busy_cnt, 172);
        check("b2b_done_cycle", done_cyc, 172);
        check("b2b_index_order", order_err, 0);

        // Hold 5 cycles in the second WAIT of element (0,0): cycles 9..13
        run_matrix(9, 5, 0);
        check("holdw_second_acum", second_acum, 17);
        check("holdw_no_pulses", hold_viol, 0);
        check("holdw_done_cycle", done_cyc, 177);
        check("holdw_acum_count", acum_cnt, 27);
        check("holdw_index_order", order_err, 0);

        // Hold over the second ISSUE (cycle 7) for 2 cycles
        run_matrix(7, 2, 0);
        check("holdi_second_gen", second_gen, 9);
        check("holdi_gen_count", gen_cnt, 27);
        check("holdi_no_pulses", hold_viol, 0);
        check("holdi_busy_cycles", busy_cnt, 174);

        // Start pulsed mid-run, and again in the DONE cycle, must be ignored
        run_matrix(0, 0, 50);
        check("midstart_busy_cycles", busy_cnt, 172);
        check("midstart_gen_count", gen_cnt, 27);
        run_matrix(0, 0, 172);
        check("donestart_busy_cycles", busy_cnt, 172);
        @(negedge clk);
        check("donestart_not_queued", int'(busy), 0);

        // Reset dropped in cycle 50 of a run
        @(posedge clk); #1;
        start = 1'b1;
        for (int cyc = 1; cyc < 50; cyc++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        @(posedge clk); #1;
        check("midreset_busy_before", int'(busy), 1);
        rst = 1'b0;
        #1;
        check("midreset_outputs", int'({gen, acum, store, done, busy, row, col, k}), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        done_seen = 0; busy_seen = 0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk);
            if (done) done_seen++;
            if (busy) busy_seen++;
        end
        check("midreset_no_done", done_seen, 0);
        check("midreset_stays_idle", busy_seen, 0);

        // DIM=1, LAT=1: {busy, gen, acum, store, done} per cycle
        exp_seq1[0] = 5'b00000;
        exp_seq1[1] = 5'b11000;
        exp_seq1[2] = 5'b10000;
        exp_seq1[3] = 5'b10100;
        exp_seq1[4] = 5'b10010;
        exp_seq1[5] = 5'b10001;
        exp_seq1[6] = 5'b00000;
        @(posedge clk); #1;
        start1 = 1'b1;
        @(negedge clk);
        check("dim1_cycle0", int'({busy1, gen1, acum1, store1, done1}), int'(exp_seq1[0]));
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(posedge clk); #1;
            start1 = 1'b0;
            @(negedge clk);
            check($sformatf("dim1_cycle%0d", cyc), int'({busy1, gen1, acum1, store1, done1}),
                  int'(exp_seq1[cyc]));
            check($sformatf("dim1_idx%0d", cyc), int'({row1, col1, k1}), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mac_sequencer.md
Name: mac_sequencer

Overview:
Parametrised control FSM for the matrix-multiply datapath. It sequences a full DIM x DIM output matrix. For each output element it runs DIM multiply-accumulate steps of the form address issue -> LAT-cycle memory wait -> accumulate, then a store/clear step. It drives the address generator, the accumulator and the result-write logic, and exposes loop indices, busy/done status and a hold input for back-pressure.

Parameters:
DIM, 3, matrix dimension: MAC steps per output element and the number of rows/columns.
LAT, 4, wait cycles between an address-issue pulse and its accumulate pulse (memory read latency); LAT >= 1.
IW, derived localparam = max(1, $clog2(DIM)), width of the index outputs.

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous active-low reset
start  in  1  request to run one full matrix; sampled only in IDLE
hold  in  1  freeze FSM and counters while high (back-pressure)
signalGenAddr  out  1  one-cycle pulse: address generator issues operand reads for (row,col,k)
signalAcum  out  1  one-cycle pulse: accumulator adds the current product
signalStore  out  1  one-cycle pulse: write accumulator to result (row,col), then clear accumulator
done  out  1  one-cycle pulse: whole matrix complete
busy  out  1  high from the cycle after start is accepted through the DONE cycle
row  out  IW  output row index
col  out  IW  output column index
k  out  IW  inner-product index

Behaviour:
- Reset (rst low, asynchronous, any state): state=IDLE. row, col, k and the wait counter are 0. busy is 0. All pulse outputs are 0.
- States: IDLE, ISSUE, WAIT, ACUM, STORE, DONE. Encoding is free.
- IDLE: if start=1 and hold=0 at an edge, go to ISSUE and clear row, col, k. Otherwise stay in IDLE.
- ISSUE: lasts 1 cycle, signalGenAddr=1. Next state is WAIT with the wait counter at 0.
- WAIT: lasts exactly LAT cycles. The counter runs 0..LAT-1. On LAT-1, reset the counter and go to ACUM.
- ACUM: lasts 1 cycle, signalAcum=1.
  - If k < DIM-1: k increments and the next state is ISSUE.
  - Otherwise: k stays at DIM-1 and the next state is STORE.
- STORE: lasts 1 cycle, signalStore=1, with row/col addressing the element being stored. Then k returns to 0.
  - Not the last element: col increments. If col = DIM-1, col goes to 0 and row increments. Next state is ISSUE.
  - row = col = DIM-1: next state is DONE.
- DONE: lasts 1 cycle, done=1. Next state is IDLE. row, col and k return to 0.
- Loop order: k innermost, then col, then row outermost. There is no wrap past row = DIM-1.
- Pulse outputs are decoded from the state register and gated by !hold. Each pulse is high exactly one cycle per visit unless hold is asserted.
- hold=1:
  - State and all counters are frozen.
  - Pulse outputs are forced low.
  - busy keeps its value.
  - The pending pulse fires in the first cycle with hold=0.
  - hold in IDLE blocks start acceptance.
- start while busy (any non-IDLE state, including DONE): ignored. It is not queued.
- busy = (state != IDLE).
- Cycle counts with no hold:
  - Per element: DIM*(LAT+2)+1 cycles.
  - Total busy cycles: DIM*DIM*(DIM*(LAT+2)+1) + 1.
- Indices are valid and stable in every non-IDLE state.
- Indices update on the edge that leaves ACUM or STORE.
- DIM=1: IW=1 and indices stay at 0. The sequence is ISSUE, WAIT x LAT, ACUM, STORE, DONE.
- Reset mid-operation: the run is abandoned immediately and no done pulse is issued. A new start is required after reset is released.

Test Plan:
- Reset check: hold rst low for 3 cycles, with start=1 during reset. Required: all outputs 0 and busy=0. After release with start low, the block stays in IDLE.
- Nominal run (DIM=3, LAT=4): 1-cycle start pulse accepted at edge 0.
  - busy is high cycles 1..172 and done is high in cycle 172.
  - Counts: 27 signalGenAddr, 27 signalAcum, 9 signalStore.
  - First signalGenAddr is in cycle 1 and first signalAcum in cycle 6.
  - First signalStore is in cycle 19 with row=0, col=0. Last signalStore has row=2, col=2.
- Index order: log (row,col,k) at each signalAcum. Required sequence: (0,0,0), (0,0,1), (0,0,2), (0,1,0) ... (2,2,2), with no repeats or gaps.
- Hold stretch: assert hold for 5 cycles during the second WAIT of element (0,0). Required: signalAcum is delayed by exactly 5 cycles and no pulses occur while held.
  - Separately, assert hold during an ISSUE cycle. Required: signalGenAddr appears once, on release.
- Start while busy / back-to-back: pulse start mid-run. Required: no effect, still 172 busy cycles.
  - Start in the cycle after done, with the FSM back in IDLE: accepted, and a second identical run follows.
- Reset mid-operation and DIM=1 variant:
  - Drop rst in cycle 50 of a run. Required: outputs go to 0 immediately, and done never fires.
  - DIM=1, LAT=1: start produces busy for 5 cycles, in order signalGenAddr, (wait), signalAcum, signalStore, done.
